uniboard_frame_tx: RTL and testbench

Transmit-side framer for the Uniboard command protocol, the counterpart of the receive-side stream decoder. It accepts tagged items (start, data byte, end) over a valid/ready handshake and emits the wire form. Start is raw 0x01, end is raw 0x17, and data bytes are escaped with 0x18 when needed. It serialises that byte stream as 8N1 UART onto the line to the control computer.

---
 rtl/uniboard_pkg.sv | 29 ++
 rtl/uart_tx_serializer.sv | 93 +++++++++
 rtl/uniboard_frame_tx.sv | 121 ++++++++++++
 tb/tb_uniboard_frame_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uniboard_pkg.sv
// Shared Uniboard protocol definitions: item tags, framing bytes, encoder states
// and the escape predicate also used by the receive-side decoder.
package uniboard_pkg;

  typedef enum logic [1:0] {
    DATA  = 2'd0,
    START = 2'd1,
    END   = 2'd2,
    RSVD  = 2'd3
  } item_kind_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_ESC  = 2'd1,
    SEND_BYTE = 2'd2
  } enc_state_t;

  localparam logic [7:0] PROTO_START = 8'h01;
  localparam logic [7:0] PROTO_END   = 8'h17;
  localparam logic [7:0] PROTO_ESC   = 8'h18;

  // A payload byte that collides with any framing byte must be preceded by ESC.
  function automatic logic needs_escape(input logic [7:0] b);
    logic hit;
    hit = (b == PROTO_START) | (b == PROTO_END) | (b == PROTO_ESC);
    return hit;
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 LSB-first UART transmitter. tx is registered one cycle behind the bit
// counters, so a load issued on the done cycle continues the line seamlessly.
module uart_tx_serializer #(
  parameter int CLK_DIV = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic             line_bit_s;
  logic             bit_end_s;

  // Level of the bit currently being timed: start, shifted data LSB, or stop.
  always_comb begin
    line_bit_s = 1'b1;
    case (bit_q)
      4'd0:    line_bit_s = 1'b0;
      4'd9:    line_bit_s = 1'b1;
      default: line_bit_s = data_q[0];
    endcase
  end

  assign bit_end_s = (div_q == DIV_LAST);

  // Divider / bit counter / shift register next-state; a load restarts everything.
  always_comb begin
    div_d  = div_q;
    bit_d  = bit_q;
    data_d = data_q;
    busy_d = busy_q;
    tx_d   = busy_q ? line_bit_s : 1'b1;
    if (load) begin
      div_d  = '0;
      bit_d  = 4'd0;
      data_d = load_data;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (bit_end_s) begin
        div_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          bit_d  = 4'd0;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q != 4'd0) begin
            data_d = {1'b0, data_q[7:1]};
          end else begin
            data_d = data_q;
          end
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = '0;
    end
  end

  // State registers with synchronous reset; line idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= '0;
      bit_q  <= 4'd0;
      data_q <= 8'h00;
      busy_q <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      data_q <= data_d;
      busy_q <= busy_d;
      tx_q   <= tx_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = busy_q & (bit_q == 4'd9) & bit_end_s;

endmodule

// File: rtl/uniboard_frame_tx.sv
// Uniboard transmit framer: turns tagged items into escaped wire bytes and
// hands them to the UART serializer one frame at a time.
module uniboard_frame_tx
  import uniboard_pkg::*;
#(
  parameter int CLK_DIV = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic [1:0] in_kind,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  enc_state_t state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] first_q, first_d;
  logic       start_q, start_d;

  logic       ser_busy_s;
  logic       ser_done_s;
  logic       ser_load_s;
  logic [7:0] ser_load_data_s;
  logic       in_ready_s;
  logic       xfer_s;

  assign in_ready_s = (state_q == IDLE) & ~ser_busy_s & ~reset;
  assign xfer_s     = in_valid & in_ready_s;

  // The escaped byte follows its ESC on the very edge the ESC frame completes.
  assign ser_load_s      = start_q | ((state_q == SEND_ESC) & ser_done_s);
  assign ser_load_data_s = start_q ? first_q : data_q;

  // Encoder next-state: pick the first wire byte at transfer, then sequence frames.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    first_d = first_q;
    start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          data_d  = in_data;
          start_d = 1'b1;
          case (item_kind_t'(in_kind))
            START: begin
              first_d = PROTO_START;
              state_d = SEND_BYTE;
            end
            END: begin
              first_d = PROTO_END;
              state_d = SEND_BYTE;
            end
            default: begin
              if (needs_escape(in_data)) begin
                first_d = PROTO_ESC;
                state_d = SEND_ESC;
              end else begin
                first_d = in_data;
                state_d = SEND_BYTE;
              end
            end
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      SEND_ESC: begin
        if (ser_done_s) begin
          state_d = SEND_BYTE;
        end else begin
          state_d = SEND_ESC;
        end
      end
      SEND_BYTE: begin
        if (ser_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND_BYTE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Encoder registers; reset discards any item in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= 8'h00;
      first_q <= 8'h00;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      first_q <= first_d;
      start_q <= start_d;
    end
  end

  uart_tx_serializer #(
    .CLK_DIV(CLK_DIV)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load_s),
    .load_data(ser_load_data_s),
    .tx       (tx),
    .busy     (ser_busy_s),
    .done     (ser_done_s)
  );

  assign in_ready = in_ready_s;
  assign busy     = (state_q != IDLE) | ser_busy_s;

endmodule

// File: tb/tb_uniboard_frame_tx.sv
// Directed self-checking bench for uniboard_frame_tx at CLK_DIV=4.
module tb_uniboard_frame_tx;

  localparam int TB_DIV = 4;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic [1:0] in_kind;
  logic       in_valid;
  logic       in_ready;
  logic       tx;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  logic [7:0] line_q[$];
  logic       mon_busy = 1'b0;
  int         mon_idx = 0;
  logic [7:0] mon_byte = 8'h00;

  uniboard_frame_tx #(.CLK_DIV(TB_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_kind (in_kind),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .tx      (tx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted items (pre-edge values of valid/ready).
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  // UART line decoder: sample mid-bit, LSB first, 4 cycles per bit.
  always @(posedge clk) begin
    if (reset) begin
      mon_busy <= 1'b0;
      mon_idx  <= 0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy <= 1'b1;
        mon_idx  <= 1;
      end
    end else begin
      if (mon_idx >= 6 && mon_idx <= 34 && (mon_idx % 4) == 2) mon_byte <= {tx, mon_byte[7:1]};
      if (mon_idx == 38) begin
        line_q.push_back(mon_byte);
        mon_busy <= 1'b0;
      end else begin
        mon_idx <= mon_idx + 1;
      end
    end
  end

  function automatic logic fbit(input logic [7:0] b, input int idx);
    logic [7:0] t;
    if (idx == 0) return 1'b0;
    else if (idx == 9) return 1'b1;
    t = b >> (idx - 1);
    return t[0];
  endfunction

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1 && busy === 1'b0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle timeout: in_ready=%b busy=%b, want 1/0", in_ready, busy);
    end
  endtask

  task automatic send_one(input logic [1:0] kind, input logic [7:0] data, input logic keep);
    logic ok = 1'b0;
    @(negedge clk);
    in_kind = kind; in_data = data; in_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (in_ready === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL send_one timeout: in_ready=%b, want 1", in_ready);
    end else begin
      @(posedge clk);
    end
    if (!keep) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_bytes(input int n);
    logic ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (line_q.size() >= n) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL wait_bytes timeout: got %0d bytes, want %0d", line_q.size(), n);
    end
    repeat (60) @(negedge clk);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp[$]);
    n_cmp++;
    if (line_q.size() !== exp.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d, want %0d", name, line_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (line_q[i] !== exp[i]) begin
          n_err++;
          $display("FAIL %s byte%0d: got %h, want %h", name, i, line_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_frame();
    logic exp_tx;
    wait_idle();
    in_kind = 2'd0; in_data = 8'h55; in_valid = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 41; n++) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      exp_tx = (n < 2) ? 1'b1 : fbit(8'h55, (n - 2) / 4);
      n_cmp++; if (tx !== exp_tx) begin n_err++; $display("FAIL t1_tx n=%0d: got %b want %b", n, tx, exp_tx); end
      n_cmp++; if (busy !== (n <= 40)) begin n_err++; $display("FAIL t1_busy n=%0d: got %b want %b", n, busy, n <= 40); end
      n_cmp++; if (in_ready !== (n == 41)) begin n_err++; $display("FAIL t1_ready n=%0d: got %b want %b", n, in_ready, n == 41); end
    end
  endtask

  task automatic test_escape();
    logic exp_tx;
    wait_idle();
    in_kind = 2'd0; in_data = 8'h17; in_valid = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 81; n++) begin
      @(negedge clk);
      if (n == 0) in_valid = 1'b0;
      if (n < 2) exp_tx = 1'b1;
      else if (n < 42) exp_tx = fbit(8'h18, (n - 2) / 4);
      else exp_tx = fbit(8'h17, (n - 42) / 4);
      n_cmp++; if (tx !== exp_tx) begin n_err++; $display("FAIL t2_tx n=%0d: got %b want %b", n, tx, exp_tx); end
      n_cmp++; if (busy !== (n <= 80)) begin n_err++; $display("FAIL t2_busy n=%0d: got %b want %b", n, busy, n <= 80); end
      n_cmp++; if (in_ready !== (n == 81)) begin n_err++; $display("FAIL t2_ready n=%0d: got %b want %b", n, in_ready, n == 81); end
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp[$];
    wait_idle();
    line_q.delete();
    acc_cnt = 0;
    send_one(2'd1, 8'h00, 1'b1);
    send_one(2'd0, 8'h41, 1'b1);
    send_one(2'd0, 8'h01, 1'b1);
    send_one(2'd0, 8'h18, 1'b1);
    send_one(2'd2, 8'h00, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_bytes(7);
    exp = '{8'h01, 8'h41, 8'h18, 8'h01, 8'h18, 8'h18, 8'h17};
    check_bytes("t3_seq", exp);
    n_cmp++; if (acc_cnt !== 5) begin n_err++; $display("FAIL t3_accepts: got %0d want 5", acc_cnt); end
  endtask

  task automatic test_start_rsvd();
    logic [7:0] exp[$];
    wait_idle();
    line_q.delete();
    acc_cnt = 0;
    send_one(2'd1, 8'hFF, 1'b0);
    send_one(2'd3, 8'h18, 1'b0);
    wait_bytes(3);
    exp = '{8'h01, 8'h18, 8'h18};
    check_bytes("t4_start_rsvd", exp);
    n_cmp++; if (acc_cnt !== 2) begin n_err++; $display("FAIL t4_accepts: got %0d want 2", acc_cnt); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] exp[$];
    int bad = 0;
    wait_idle();
    line_q.delete();
    in_kind = 2'd0; in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (18) @(negedge clk);
    n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL t5_d3: got %b want 0", tx); end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL t5_tx_after_reset: got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL t5_busy_after_reset: got %b want 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready_in_reset: got %b want 0", in_ready); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL t5_ready_after: got %b want 1", in_ready); end
    for (int c = 0; c < 50; c++) begin
      if (tx !== 1'b1) bad++;
      @(negedge clk);
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL t5_quiet_line: got %0d low cycles want 0", bad); end
    n_cmp++; if (line_q.size() !== 0) begin n_err++; $display("FAIL t5_no_bytes: got %0d want 0", line_q.size()); end
    send_one(2'd0, 8'h3C, 1'b0);
    wait_bytes(1);
    exp = '{8'h3C};
    check_bytes("t5_recover", exp);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$];
    wait_idle();
    line_q.delete();
    acc_cnt = 0;
    in_kind = 2'd0; in_data = 8'h11; in_valid = 1'b1;
    @(posedge clk);
    for (int n = 0; n <= 124; n++) begin
      @(negedge clk);
      in_data = 8'h40 + 8'(n);
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_bytes(3);
    exp = '{8'h11, 8'h69, 8'h93};
    check_bytes("t6_held", exp);
    n_cmp++; if (acc_cnt !== 3) begin n_err++; $display("FAIL t6_accepts: got %0d want 3", acc_cnt); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_frame();
    test_escape();
    test_sequence();
    test_start_rsvd();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
